ppu_chr_arb: RTL

Arbiter and cycle sequencer for the PPU's external CHR SRAM (4K×16, async). It shares the SRAM between three requesters: render-engine pattern fetches, CPU $2007 byte accesses and the CHR image loader. It generates the SRAM strobes with fixed read and write timing and enforces the write-protect input. It sits between those requesters and the board SRAM pins, in the PPU clock domain.

---
 rtl/ppu_pkg.sv | 27 ++
 rtl/ppu_chr_arb_pri.sv | 61 ++++++
 rtl/ppu_chr_arb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and default timing constants for the PPU CHR SRAM
// arbiter.
//   state_t    - sequencer state encoding (IDLE, RD, WR_SU, WR_PL, WR_HD)
//   req_id_t   - requester identity (none / render / CPU / loader)
//   *_DEF      - default strobe timing and CPU starvation limit
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_SU = 3'd2,
        ST_WR_PL = 3'd3,
        ST_WR_HD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ID_NONE = 2'd0,
        ID_RDE  = 2'd1,
        ID_CPU  = 2'd2,
        ID_LD   = 2'd3
    } req_id_t;

    localparam int RD_CYCLES_DEF    = 2;
    localparam int WR_PULSE_DEF     = 2;
    localparam int CPU_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/ppu_chr_arb_pri.sv
// ppu_chr_arb_pri: combinational priority select plus CPU aging counter.
//   i_clk, i_rstn - PPU clock, async active-low reset
//   idle          - sequencer is in IDLE; a grant can only be issued then
//   rde_req       - render request
//   cpu_req       - CPU request
//   ld_req        - loader request
//   sel           - requester granted this cycle (ID_NONE if none)
// Render normally beats CPU, CPU beats loader. Once CPU_MAX_WAIT render
// grants have gone by with the CPU still waiting, the CPU jumps the queue.
module ppu_chr_arb_pri
    import ppu_pkg::*;
#(
    parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
    input  logic    i_clk,
    input  logic    i_rstn,
    input  logic    idle,
    input  logic    rde_req,
    input  logic    cpu_req,
    input  logic    ld_req,
    output req_id_t sel
);

    localparam int AW = $clog2(CPU_MAX_WAIT + 1);

    logic [AW-1:0] age;
    logic          cpu_aged;

    assign cpu_aged = (age == AW'(CPU_MAX_WAIT));

    // NOTE: sel gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        sel = ID_NONE;
        if (idle) begin
            if (cpu_req && cpu_aged)
                sel = ID_CPU;
            else if (rde_req)
                sel = ID_RDE;
            else if (cpu_req)
                sel = ID_CPU;
            else if (ld_req)
                sel = ID_LD;
        end
    end

    // Age counts render grants that overtook a waiting CPU. It is only
    // meaningful while the CPU keeps its request up.
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            age <= '0;
        end else if (!cpu_req || sel == ID_CPU) begin
            age <= '0;
        end else if (sel == ID_RDE && !cpu_aged) begin
            age <= age + AW'(1);
        end
    end

endmodule

// File: rtl/ppu_chr_arb.sv
// ppu_chr_arb: arbiter and strobe sequencer for the 4Kx16 async CHR SRAM.
//   i_clk, i_rstn          - PPU clock, async active-low reset
//   i_rde_* / o_rde_*      - render word reads (grant, valid, data)
//   i_cpu_* / o_cpu_*      - CPU byte reads/writes (ack, read byte)
//   i_ld_* / o_ld_ack      - loader word writes
//   i_sram_wp              - write protect; writes are acked but not strobed
//   o_sram_*, i_sram_rdata - SRAM pins; all strobes active low
//   o_busy                 - sequencer is not in IDLE
// Reads:  IDLE -> RD (RD_CYCLES) -> IDLE, data captured at end of last RD.
// Writes: IDLE -> WR_SU -> WR_PL (WR_PULSE, we_n low) -> WR_HD -> IDLE.
// All strobes, address and write data are registered.
module ppu_chr_arb
    import ppu_pkg::*;
#(
    parameter int RD_CYCLES    = RD_CYCLES_DEF,
    parameter int WR_PULSE     = WR_PULSE_DEF,
    parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rde_req,
    input  logic [11:0] i_rde_addr,
    output logic        o_rde_gnt,
    output logic        o_rde_vld,
    output logic [15:0] o_rde_rdata,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [12:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_ld_req,
    input  logic [11:0] i_ld_addr,
    input  logic [15:0] i_ld_wdata,
    output logic        o_ld_ack,
    input  logic        i_sram_wp,
    output logic [11:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    input  logic [15:0] i_sram_rdata,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n,
    output logic        o_busy
);

    localparam int CNT_MAX = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    req_id_t       sel;
    req_id_t       op_id;     // owner of the access in flight
    logic          byte_hi;   // CPU byte lane of the access in flight
    logic [CW-1:0] cnt;       // cycles left in RD / WR_PL, minus one

    ppu_chr_arb_pri #(
        .CPU_MAX_WAIT (CPU_MAX_WAIT)
    ) u_pri (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .idle    (state == ST_IDLE),
        .rde_req (i_rde_req),
        .cpu_req (i_cpu_req),
        .ld_req  (i_ld_req),
        .sel     (sel)
    );

    assign o_rde_gnt = (sel == ID_RDE);
    assign o_busy    = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            op_id        <= ID_NONE;
            byte_hi      <= 1'b0;
            cnt          <= '0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_rde_vld    <= 1'b0;
            o_rde_rdata  <= '0;
            o_cpu_ack    <= 1'b0;
            o_cpu_rdata  <= '0;
            o_ld_ack     <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            o_rde_vld <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_ld_ack  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    case (sel)
                        ID_RDE: begin
                            op_id       <= ID_RDE;
                            o_sram_addr <= i_rde_addr;
                            state       <= ST_RD;
                            cnt         <= CW'(RD_CYCLES - 1);
                            o_sram_oe_n <= 1'b0;
                            o_sram_ub_n <= 1'b0;
                            o_sram_lb_n <= 1'b0;
                        end
                        ID_CPU: begin
                            op_id        <= ID_CPU;
                            byte_hi      <= i_cpu_addr[0];
                            o_sram_addr  <= i_cpu_addr[12:1];
                            o_sram_wdata <= {i_cpu_wdata, i_cpu_wdata};
                            if (!i_cpu_we) begin
                                state       <= ST_RD;
                                cnt         <= CW'(RD_CYCLES - 1);
                                o_sram_oe_n <= 1'b0;
                                o_sram_ub_n <= 1'b0;
                                o_sram_lb_n <= 1'b0;
                            end else if (i_sram_wp) begin
                                // Protected: skip straight to hold and ack.
                                state     <= ST_WR_HD;
                                o_cpu_ack <= 1'b1;
                            end else begin
                                state       <= ST_WR_SU;
                                o_sram_ub_n <= ~i_cpu_addr[0];
                                o_sram_lb_n <= i_cpu_addr[0];
                            end
                        end
                        ID_LD: begin
                            op_id        <= ID_LD;
                            o_sram_addr  <= i_ld_addr;
                            o_sram_wdata <= i_ld_wdata;
                            if (i_sram_wp) begin
                                state    <= ST_WR_HD;
                                o_ld_ack <= 1'b1;
                            end else begin
                                state       <= ST_WR_SU;
                                o_sram_ub_n <= 1'b0;
                                o_sram_lb_n <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end

                ST_RD: begin
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        o_sram_oe_n <= 1'b1;
                        o_sram_ub_n <= 1'b1;
                        o_sram_lb_n <= 1'b1;
                        if (op_id == ID_RDE) begin
                            o_rde_vld   <= 1'b1;
                            o_rde_rdata <= i_sram_rdata;
                        end else begin
                            o_cpu_ack   <= 1'b1;
                            o_cpu_rdata <= byte_hi ? i_sram_rdata[15:8]
                                                   : i_sram_rdata[7:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_WR_SU: begin
                    state       <= ST_WR_PL;
                    cnt         <= CW'(WR_PULSE - 1);
                    o_sram_we_n <= 1'b0;
                end

                ST_WR_PL: begin
                    if (cnt == '0) begin
                        state       <= ST_WR_HD;
                        o_sram_we_n <= 1'b1;
                        if (op_id == ID_CPU)
                            o_cpu_ack <= 1'b1;
                        else
                            o_ld_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_WR_HD: begin
                    // Address/data held through this cycle; release lanes.
                    state       <= ST_IDLE;
                    o_sram_ub_n <= 1'b1;
                    o_sram_lb_n <= 1'b1;
                end

                default: begin
                    state       <= ST_IDLE;
                    o_sram_oe_n <= 1'b1;
                    o_sram_we_n <= 1'b1;
                    o_sram_ub_n <= 1'b1;
                    o_sram_lb_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
